spi_slave_ctrl: RTL and testbench

- Synthesizable SPI slave (responder): the target-side counterpart of the SPI master transfer the team's AVIP drives.
- Oversamples sclk, cs and mosi in the pclk domain.
- Deserialises CHAR_LENGTH-bit characters onto an rx strobe, and serialises tx characters from a one-entry holding buffer onto miso.
- Supports all four CPOL/CPHA modes and both shift directions, so the slave VIP can be checked against real RTL.

---
 rtl/spi_globals_pkg.sv | 24 ++
 rtl/spi_sync_edge_detect.sv | 42 ++++
 rtl/spi_slave_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_spi_slave_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_globals_pkg.sv
// Shared SPI types and defaults used by the SPI slave controller and its helpers.
package spi_globals_pkg;

  localparam int unsigned CHAR_LENGTH = 8;

  // Encoded as {cpol, cpha}.
  typedef enum logic [1:0] {
    Mode0 = 2'b00,
    Mode1 = 2'b01,
    Mode2 = 2'b10,
    Mode3 = 2'b11
  } operation_modes_e;

  typedef enum logic {
    LsbFirst = 1'b0,
    MsbFirst = 1'b1
  } shift_direction_e;

  typedef enum logic {
    StIdle   = 1'b0,
    StActive = 1'b1
  } spi_slave_state_e;

endpackage

// File: rtl/spi_sync_edge_detect.sv
// Multi-flop synchroniser with a configurable reset level and registered rise/fall pulses.
module spi_sync_edge_detect #(
  parameter int unsigned Stages     = 2,
  parameter logic        ResetLevel = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[Stages-2:0], d_i};
    prev_d = sync_q[Stages-1];
    rise_d = sync_q[Stages-1] & ~prev_q;
    fall_d = ~sync_q[Stages-1] & prev_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q <= {Stages{ResetLevel}};
      prev_q <= ResetLevel;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave: oversamples sclk/cs/mosi in pclk, deserialises rx characters and
// serialises tx characters from a one-entry holding buffer, all four CPOL/CPHA modes.
module spi_slave_ctrl #(
  parameter int unsigned            CHAR_LENGTH  = spi_globals_pkg::CHAR_LENGTH,
  parameter int unsigned            SYNC_STAGES  = 2,
  parameter logic [CHAR_LENGTH-1:0] IDLE_PATTERN = {CHAR_LENGTH{1'b1}}
) (
  input  logic                   pclk,
  input  logic                   areset,
  input  logic                   sclk,
  input  logic                   cs,
  input  logic                   mosi,
  output logic                   miso,
  output logic                   miso_oe,
  input  logic [1:0]             mode,
  input  logic                   shift_dir,
  input  logic [CHAR_LENGTH-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [CHAR_LENGTH-1:0] rx_data,
  output logic                   rx_valid,
  output logic                   underrun,
  output logic                   frame_error,
  output logic                   busy
);
  import spi_globals_pkg::*;

  localparam int unsigned     CntW         = $clog2(CHAR_LENGTH);
  localparam logic [CntW-1:0] LastBit      = CntW'(CHAR_LENGTH - 1);
  localparam int unsigned     SettleCycles = SYNC_STAGES + 3;
  localparam int unsigned     SettleW      = $clog2(SettleCycles + 1);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  spi_sync_edge_detect #(.Stages(SYNC_STAGES), .ResetLevel(1'b0)) u_sclk_sync (
    .clk_i  (pclk),
    .rst_ni (areset),
    .d_i    (sclk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync_edge_detect #(.Stages(SYNC_STAGES), .ResetLevel(1'b1)) u_cs_sync (
    .clk_i  (pclk),
    .rst_ni (areset),
    .d_i    (cs),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  spi_slave_state_e       state_q, state_d;
  operation_modes_e       mode_q, mode_d;
  shift_direction_e       dir_q, dir_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [CHAR_LENGTH-1:0] tx_shift_q, tx_shift_d;
  logic [CHAR_LENGTH-1:0] rx_shift_q, rx_shift_d;
  logic [CHAR_LENGTH-1:0] rx_data_q, rx_data_d;
  logic [CHAR_LENGTH-1:0] buf_q, buf_d;
  logic                   buf_full_q, buf_full_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   underrun_q, underrun_d;
  logic                   frame_error_q, frame_error_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SettleW-1:0]     settle_q, settle_d;

  logic                   settled, do_load, cpol, cpha;
  logic                   lead_edge, trail_edge, sample_edge, shift_edge;
  logic [CHAR_LENGTH-1:0] rx_next;

  // A cs fall produced while the synchroniser flushes its reset level is not a real assertion.
  assign settled = (settle_q == SettleW'(SettleCycles));

  assign cpol        = mode_q[1];
  assign cpha        = mode_q[0];
  assign lead_edge   = cpol ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol ? sclk_rise : sclk_fall;
  assign sample_edge = cpha ? trail_edge : lead_edge;
  assign shift_edge  = cpha ? lead_edge : trail_edge;

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    dir_d         = dir_q;
    cnt_d         = cnt_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    rx_data_d     = rx_data_q;
    buf_d         = buf_q;
    buf_full_d    = buf_full_q;
    rx_valid_d    = 1'b0;
    underrun_d    = 1'b0;
    frame_error_d = 1'b0;
    do_load       = 1'b0;
    rx_next       = rx_shift_q;
    mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    settle_d      = settled ? settle_q : settle_q + 1'b1;

    if (tx_valid && !buf_full_q) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (cs_fall && settled) begin
          state_d    = StActive;
          mode_d     = operation_modes_e'(mode);
          dir_d      = shift_direction_e'(shift_dir);
          cnt_d      = '0;
          rx_shift_d = '0;
          do_load    = ~mode[0];
        end
      end
      StActive: begin
        if (cs_rise) begin
          state_d       = StIdle;
          frame_error_d = (cnt_q != '0);
          cnt_d         = '0;
        end else if (sample_edge) begin
          rx_next    = (dir_q == MsbFirst) ?
                       {rx_shift_q[CHAR_LENGTH-2:0], mosi_sync_q[SYNC_STAGES-1]} :
                       {mosi_sync_q[SYNC_STAGES-1], rx_shift_q[CHAR_LENGTH-1:1]};
          rx_shift_d = rx_next;
          if (cnt_q == LastBit) begin
            cnt_d      = '0;
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (shift_edge) begin
          // A shift edge at bit 0 starts a new character in either phase.
          if (cnt_q == '0) begin
            do_load = 1'b1;
          end else begin
            tx_shift_d = (dir_q == MsbFirst) ? (tx_shift_q << 1) : (tx_shift_q >> 1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_load) begin
      if (buf_full_q) begin
        tx_shift_d = buf_q;
        buf_full_d = 1'b0;
      end else begin
        tx_shift_d = IDLE_PATTERN;
        underrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!areset) begin
      state_q       <= StIdle;
      mode_q        <= Mode0;
      dir_q         <= LsbFirst;
      cnt_q         <= '0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      rx_data_q     <= '0;
      buf_q         <= '0;
      buf_full_q    <= 1'b0;
      rx_valid_q    <= 1'b0;
      underrun_q    <= 1'b0;
      frame_error_q <= 1'b0;
      mosi_sync_q   <= '0;
      settle_q      <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      dir_q         <= dir_d;
      cnt_q         <= cnt_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      rx_data_q     <= rx_data_d;
      buf_q         <= buf_d;
      buf_full_q    <= buf_full_d;
      rx_valid_q    <= rx_valid_d;
      underrun_q    <= underrun_d;
      frame_error_q <= frame_error_d;
      mosi_sync_q   <= mosi_sync_d;
      settle_q      <= settle_d;
    end
  end

  assign miso        = (dir_q == MsbFirst) ? tx_shift_q[CHAR_LENGTH-1] : tx_shift_q[0];
  assign miso_oe     = (state_q == StActive);
  assign busy        = (state_q == StActive);
  assign tx_ready    = ~buf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign underrun    = underrun_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Self-checking bench for spi_slave_ctrl: directed mode/order cases plus random frames
// compared against a character-level model of loads, underruns and received data.
module tb_spi_slave_ctrl;

  localparam int H = 8;  // sclk half period in pclk cycles

  logic       pclk = 1'b0;
  logic       areset = 1'b0;
  logic       sclk = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       shift_dir = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       miso, miso_oe, tx_ready, rx_valid, underrun, frame_error, busy;
  logic [7:0] rx_data;

  int n_cmp = 0;
  int n_fail = 0;
  int ur_cnt = 0;
  int fe_cnt = 0;
  int ur_start = 0;
  logic rdy_start = 1'b0;
  logic [7:0] tx_q[$];
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  logic [7:0] rx_got[$];
  logic [7:0] cur_tx[$];
  logic [7:0] cur_mos[$];

  always #5 pclk = ~pclk;

  spi_slave_ctrl dut (
    .pclk        (pclk),
    .areset      (areset),
    .sclk        (sclk),
    .cs          (cs),
    .mosi        (mosi),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .mode        (mode),
    .shift_dir   (shift_dir),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .underrun    (underrun),
    .frame_error (frame_error),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Feeds the holding buffer from tx_q whenever it is empty.
  task automatic refill_loop();
    forever begin
      @(negedge pclk);
      if (tx_valid) tx_valid = 1'b0;
      else if (areset && tx_ready && tx_q.size() != 0) begin
        tx_data  = tx_q.pop_front();
        tx_valid = 1'b1;
      end
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge pclk);
      if (rx_valid) rx_got.push_back(rx_data);
      if (underrun) ur_cnt++;
      if (frame_error) fe_cnt++;
    end
  endtask

  task automatic wait_preload();
    int t = 0;
    repeat (3) @(negedge pclk);
    while (!((tx_q.size() == 0 || !tx_ready) && !tx_valid) && t < 50) begin
      @(negedge pclk);
      t++;
    end
    check("preload_in_time", (t < 50), 1);
  endtask

  // Master side: drives nbits of m_tx, captures miso at each sample edge.
  task automatic run_frame(input logic [1:0] md, input logic dr, input int nbits,
                           input bit keep_cs);
    logic [7:0] cap = 8'h00;
    @(negedge pclk);
    mode = md; shift_dir = dr; sclk = md[1];
    repeat (H) @(negedge pclk);
    cs = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      int bi = b % 8;
      int pos = dr ? 7 - bi : bi;
      logic [7:0] ch = m_tx[b / 8];
      if (md[0] == 1'b0) begin
        mosi = ch[pos];
        repeat (H) @(negedge pclk);
        if (b == 0) begin ur_start = ur_cnt; rdy_start = tx_ready; end
        sclk = ~md[1]; cap[pos] = miso;
        repeat (H) @(negedge pclk);
        sclk = md[1];
      end else begin
        repeat (H) @(negedge pclk);
        if (b == 0) begin ur_start = ur_cnt; rdy_start = tx_ready; end
        sclk = ~md[1]; mosi = ch[pos];
        repeat (H) @(negedge pclk);
        sclk = md[1]; cap[pos] = miso;
      end
      if (bi == 7) m_rx.push_back(cap);
    end
    if (!keep_cs) begin
      repeat (H) @(negedge pclk);
      cs = 1'b1;
      repeat (2 * H) @(negedge pclk);
    end
  endtask

  task automatic clear_obs();
    rx_got.delete(); m_rx.delete();
    ur_cnt = 0; fe_cnt = 0;
  endtask

  // Model: cpha=0 loads at cs assert and after every character, cpha=1 once per character;
  // each load takes the next written character or the idle pattern with an underrun.
  task automatic do_frame(input string tag, input logic [1:0] md, input logic dr);
    int n = cur_mos.size();
    int loads = md[0] ? n : n + 1;
    int exp_ur = (loads > cur_tx.size()) ? loads - cur_tx.size() : 0;
    clear_obs();
    m_tx = cur_mos;
    tx_q = cur_tx;
    wait_preload();
    run_frame(md, dr, n * 8, 1'b0);
    check({tag, "_rx_count"}, rx_got.size(), n);
    check({tag, "_miso_count"}, m_rx.size(), n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] exp_miso = (i < cur_tx.size()) ? cur_tx[i] : 8'hFF;
      if (i < rx_got.size()) check({tag, "_rx_char"}, rx_got[i], cur_mos[i]);
      if (i < m_rx.size()) check({tag, "_miso_char"}, m_rx[i], exp_miso);
    end
    check({tag, "_rx_data"}, rx_data, cur_mos[n-1]);
    check({tag, "_underruns"}, ur_cnt, exp_ur);
    check({tag, "_frame_err"}, fe_cnt, 0);
    check({tag, "_idle_oe"}, {busy, miso_oe}, 2'b00);
  endtask

  initial begin
    fork
      refill_loop();
      monitor_loop();
      begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (4) @(negedge pclk);
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_pulses", {rx_valid, underrun, frame_error}, 3'b000);
    check("rst_busy", busy, 0);
    areset = 1'b1;
    repeat (10) @(negedge pclk);

    // mode0, MSB first
    cur_tx.delete(); cur_mos.delete();
    cur_tx.push_back(8'h3C); cur_mos.push_back(8'hA5);
    do_frame("m0_msb", 2'b00, 1'b1);
    check("m0_ready_at_cs", rdy_start, 1);

    // mode3, LSB first
    cur_tx.delete(); cur_mos.delete();
    cur_tx.push_back(8'h81); cur_mos.push_back(8'h12);
    do_frame("m3_lsb", 2'b11, 1'b0);

    // mode1 back-to-back
    cur_tx.delete(); cur_mos.delete();
    cur_tx.push_back(8'h11); cur_tx.push_back(8'h22);
    cur_mos.push_back(8'hF0); cur_mos.push_back(8'h0F);
    do_frame("m1_b2b", 2'b01, 1'b1);

    // mode2, empty buffer
    cur_tx.delete(); cur_mos.delete();
    cur_mos.push_back(8'h55);
    do_frame("m2_underrun", 2'b10, 1'b1);
    check("m2_underrun_at_cs", ur_start, 1);

    // cs released after 5 bits
    clear_obs();
    m_tx.delete(); m_tx.push_back(8'h96);
    tx_q.push_back(8'h5A);
    wait_preload();
    run_frame(2'b00, 1'b1, 5, 1'b0);
    check("abort_frame_err", fe_cnt, 1);
    check("abort_no_rx", rx_got.size(), 0);
    check("abort_idle", {busy, miso_oe}, 2'b00);
    cur_tx.delete(); cur_mos.delete();
    cur_tx.push_back(8'($urandom)); cur_mos.push_back(8'($urandom));
    do_frame("after_abort", 2'b00, 1'b1);

    // reset in the middle of bit 3
    clear_obs();
    m_tx.delete(); m_tx.push_back(8'hE7);
    tx_q.push_back(8'hAA);
    wait_preload();
    run_frame(2'b00, 1'b1, 3, 1'b1);
    areset = 1'b0;
    @(negedge pclk);
    check("midrst_miso", miso, 0);
    check("midrst_miso_oe", miso_oe, 0);
    check("midrst_tx_ready", tx_ready, 1);
    check("midrst_rx_data", rx_data, 0);
    check("midrst_busy", busy, 0);
    cs = 1'b1; sclk = 1'b0;
    repeat (4) @(negedge pclk);
    areset = 1'b1;
    repeat (2 * H) @(negedge pclk);
    check("midrst_no_pulses", {fe_cnt[7:0], 8'(rx_got.size())}, 16'h0000);
    cur_tx.delete(); cur_mos.delete();
    cur_tx.push_back(8'h3C); cur_mos.push_back(8'hC3);
    do_frame("after_rst", 2'b00, 1'b1);

    // random frames
    for (int r = 0; r < 8; r++) begin
      logic [1:0] md = 2'($urandom_range(0, 3));
      logic dr = 1'($urandom_range(0, 1));
      int n = $urandom_range(1, 3);
      int loads = md[0] ? n : n + 1;
      int k = $urandom_range(0, loads);
      cur_tx.delete(); cur_mos.delete();
      for (int i = 0; i < k; i++) cur_tx.push_back(8'($urandom));
      for (int i = 0; i < n; i++) cur_mos.push_back(8'($urandom));
      do_frame($sformatf("rand%0d", r), md, dr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
